// File: rtl/mcpu_bus_target_pkg.sv
// Shared definitions for the MCPU data-bus target: register addresses, STATUS bit positions
// and the address-decode selector.
package mcpu_bus_target_pkg;

   localparam int unsigned MCPU_BUS_ADDR_TXDATA = 32'h100;
   localparam int unsigned MCPU_BUS_ADDR_RXDATA = 32'h101;
   localparam int unsigned MCPU_BUS_ADDR_STATUS = 32'h102;
   localparam int unsigned MCPU_BUS_ADDR_CYCLES = 32'h103;

   localparam int STAT_TX_FULL     = 0;
   localparam int STAT_RX_AVAIL    = 1;
   localparam int STAT_TX_OVERFLOW = 2;
   localparam int STAT_RX_UNDERFLW = 3;
   localparam int STAT_TXCNT_LSB   = 8;
   localparam int STAT_RXCNT_LSB   = 12;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_TXDATA,
      SEL_RXDATA,
      SEL_STATUS,
      SEL_CYCLES
   } reg_sel_e;

endpackage

// File: rtl/mcpu_bus_target_byte_fifo.sv
// Byte FIFO with occupancy count; head reads 0 when empty.
// A pop on a full FIFO frees the slot for a push on the same edge.
module mcpu_byte_fifo #(
   parameter int FIFO_DEPTH = 4,
   localparam int PW = $clog2(FIFO_DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == CW'(FIFO_DEPTH));
   assign count  = r_count;
   assign head   = empty ? 8'h00 : r_mem[r_rd_ptr];
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mcpu_bus_target.sv
// MCPU data-bus target: word RAM, TX/RX byte FIFOs and STATUS; combinational read, edge-committed side effects.
// Optional free-running cycle counter at CYCLES when MCPU_BUS_TARGET_CYCLES_EN is defined.
module mcpu_bus_target
   import mcpu_bus_target_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RAM_WORDS  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic                  re,
   input  logic                  we,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] r_ram [RAM_WORDS];
   logic                  r_tx_ovf;
   logic                  r_rx_unf;
   reg_sel_e              w_sel;
   logic [CW-1:0]         w_tx_count, w_rx_count;
   logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [7:0]            w_rx_head;
   logic                  w_tx_pop, w_tx_push_req, w_tx_drop;
   logic                  w_rx_push, w_rx_pop_req, w_rx_pop, w_rx_unf_set;
   logic [DATA_WIDTH-1:0] w_tx_cnt_ext, w_rx_cnt_ext, w_status;

   always_comb begin
      w_sel = SEL_NONE;
      if (addr < DATA_WIDTH'(RAM_WORDS))                       w_sel = SEL_RAM;
      else if (addr == DATA_WIDTH'(MCPU_BUS_ADDR_TXDATA))      w_sel = SEL_TXDATA;
      else if (addr == DATA_WIDTH'(MCPU_BUS_ADDR_RXDATA))      w_sel = SEL_RXDATA;
      else if (addr == DATA_WIDTH'(MCPU_BUS_ADDR_STATUS))      w_sel = SEL_STATUS;
      else if (addr == DATA_WIDTH'(MCPU_BUS_ADDR_CYCLES))      w_sel = SEL_CYCLES;
   end

   assign tx_valid      = !w_tx_empty;
   assign rx_ready      = !w_rx_full;
   assign w_tx_pop      = tx_valid && tx_ready;
   assign w_tx_push_req = we && (w_sel == SEL_TXDATA);
   assign w_tx_drop     = w_tx_push_req && w_tx_full && !w_tx_pop;
   assign w_rx_push     = rx_valid && rx_ready;
   assign w_rx_pop_req  = re && (w_sel == SEL_RXDATA);
   assign w_rx_pop      = w_rx_pop_req && !w_rx_empty;
   assign w_rx_unf_set  = w_rx_pop_req && w_rx_empty;

   mcpu_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n),
      .push(w_tx_push_req), .push_data(wdata[7:0]), .pop(w_tx_pop),
      .head(tx_data), .count(w_tx_count), .full(w_tx_full), .empty(w_tx_empty)
   );

   mcpu_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n),
      .push(w_rx_push), .push_data(rx_data), .pop(w_rx_pop),
      .head(w_rx_head), .count(w_rx_count), .full(w_rx_full), .empty(w_rx_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RAM_WORDS; i++) r_ram[i] <= '0;
      end else if (we && (w_sel == SEL_RAM)) begin
         r_ram[addr[AW-1:0]] <= wdata;
      end
   end

   // A new error event on the same edge as a STATUS write keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_ovf <= 1'b0;
         r_rx_unf <= 1'b0;
      end else begin
         if (w_tx_drop)                         r_tx_ovf <= 1'b1;
         else if (we && (w_sel == SEL_STATUS))  r_tx_ovf <= 1'b0;
         if (w_rx_unf_set)                      r_rx_unf <= 1'b1;
         else if (we && (w_sel == SEL_STATUS))  r_rx_unf <= 1'b0;
      end
   end

`ifdef MCPU_BUS_TARGET_CYCLES_EN
   logic [DATA_WIDTH-1:0] r_cycles;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          r_cycles <= '0;
      else if (we && (w_sel == SEL_CYCLES))  r_cycles <= wdata;
      else                                   r_cycles <= r_cycles + 1'b1;
   end
`endif

   assign w_tx_cnt_ext = DATA_WIDTH'(w_tx_count);
   assign w_rx_cnt_ext = DATA_WIDTH'(w_rx_count);

   always_comb begin
      w_status                              = '0;
      w_status[STAT_TX_FULL]                = w_tx_full;
      w_status[STAT_RX_AVAIL]               = !w_rx_empty;
      w_status[STAT_TX_OVERFLOW]            = r_tx_ovf;
      w_status[STAT_RX_UNDERFLW]            = r_rx_unf;
      w_status[STAT_TXCNT_LSB +: 4]         = w_tx_cnt_ext[3:0];
      w_status[STAT_RXCNT_LSB +: 4]         = w_rx_cnt_ext[3:0];
   end

   always_comb begin
      rdata = '0;
      case (w_sel)
         SEL_RAM:    rdata = r_ram[addr[AW-1:0]];
         SEL_TXDATA: rdata = w_tx_cnt_ext;
         SEL_RXDATA: rdata = DATA_WIDTH'(w_rx_head);
         SEL_STATUS: rdata = w_status;
`ifdef MCPU_BUS_TARGET_CYCLES_EN
         SEL_CYCLES: rdata = r_cycles;
`endif
         default:    rdata = '0;
      endcase
   end

endmodule
